wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage: the write-side master of the register file. Accepts retiring instructions from MEM.
//  Waits for load data, aligns it and sign/zero-extends it. Emits one registered write per instruction
//  on the register file's write port (regwrite/jal_ra/wr_in/write_data_in/memread). Exposes pending-load
//  status so hazard logic can stall dependent reads.
// PARAMETERS
//  W            32  datapath / register width
//  LINK_OFFSET  8   added to in_pc to form the jal link value written to r31
// PORTS
//  clock          in   1   clock, all state updates on posedge
//  reset          in   1   reset, synchronous, active-high
//  in_valid       in   1   MEM stage presents an instruction
//  in_ready       out  1   stage can accept (1 only in IDLE)
//  in_regwrite    in   1   instruction writes a register
//  in_memread     in   1   instruction is a load
//  in_jal         in   1   jal: write in_pc+LINK_OFFSET to r31
//  in_rd          in   5   destination register
//  in_alu_result  in   W   ALU result / load address ([1:0] = byte offset)
//  in_pc          in   W   PC of instruction
//  in_ld_size     in   2   00 byte, 01 half, 10/11 word
//  in_ld_unsigned in   1   zero-extend (1) / sign-extend (0)
//  mem_rvalid     in   1   load data valid this cycle
//  mem_rdata      in   W   raw aligned word from data memory
//  wb_regwrite    out  1   -> regfile regwrite
//  wb_jal_ra      out  1   -> regfile jal_ra
//  wb_wr          out  5   -> regfile wr_in
//  wb_data        out  W   -> regfile write_data_in
//  wb_memread     out  1   -> regfile memread (write originates from a load)
//  load_pending   out  1   load accepted, data not yet returned
//  pending_rd     out  5   destination of pending load (0 when none)
//  err_misalign   out  1   sticky: misaligned half/word load seen
// BEHAVIOUR
//  - Reset: state IDLE, every output 0 (in_ready becomes 1 the cycle after reset drops). Reset during
//    WAIT_LOAD drops the load; no write is issued.
//  - States: IDLE, WAIT_LOAD. Accept = in_valid & in_ready at posedge.
//  - IDLE, accept, in_jal=1: during the next cycle, wb_regwrite=in_regwrite, wb_jal_ra=in_regwrite,
//    wb_wr=31, wb_data=in_pc+LINK_OFFSET (mod 2^W), wb_memread=0. jal takes priority over in_memread;
//    the stage does not wait.
//  - IDLE, accept, non-load: next cycle wb_regwrite=in_regwrite&(in_rd!=0), wb_wr=in_rd,
//    wb_data=in_alu_result.
//  - IDLE, accept, load: capture rd, size, unsigned, offset; go to WAIT_LOAD. load_pending=1 and
//    pending_rd=rd from the next cycle on.
//  - WAIT_LOAD, mem_rvalid=1 at posedge: go to IDLE. During the next cycle: wb_memread=1, wb_wr=rd,
//    wb_data=aligned value, wb_regwrite=regwrite&(rd!=0)&~misaligned. load_pending drops in that same cycle.
//  - Write outputs are a 1-cycle pulse. In idle cycles wb_regwrite/wb_jal_ra/wb_memread=0; wb_wr/wb_data hold.
//  - Throughput: 1 instr/cycle for non-loads. A load occupies the stage from accept to mem_rvalid+1.
//    mem_rvalid in IDLE is ignored.
//  - Alignment: byte=rdata[8*off+:8]; half=rdata[16*off[1]+:16] (misaligned if off[0]);
//    word=rdata (misaligned if off!=0). Extension to W bits by in_ld_unsigned.
//  - Misaligned load: write suppressed, err_misalign set, cleared only by reset.
//  - rd=0 non-jal: no write pulse, but the instruction still completes normally.
// STRUCTURE
//  - package wb_pkg: LD_BYTE/LD_HALF/LD_WORD codes, REG_RA=5'd31, state enum {IDLE,WAIT_LOAD}.
//  - sub-module load_align (combinational: rdata, size, offset, unsigned -> data, misaligned);
//    wb_stage holds the FSM, capture registers and output registers.
// TESTING
//  - ALU op rd=5, result 0x1234, in_pc=0x400 -> next cycle wb_regwrite=1, wb_wr=5, wb_data=0x1234, pulse 1 cycle.
//  - jal in_pc=0x00400010 -> wb_jal_ra=1, wb_wr=31, wb_data=0x00400018. Again with rd=0 and in_memread=1:
//    same result, no wait.
//  - lb off=3, rdata=0x80FF7F01, signed -> in_ready=0 until mem_rvalid (3-cycle delay), then
//    wb_data=0xFFFFFF80, wb_memread=1. Same with lbu -> 0x00000080.
//  - lh off=2, rdata=0xBEEF0000 -> 0xFFFFBEEF. lw off=2 -> no write, err_misalign=1, stays set.
//  - Reset asserted in WAIT_LOAD, then mem_rvalid pulses -> no write, outputs 0, load_pending=0.
//  - Back-to-back: 4 ALU ops on consecutive cycles -> 4 consecutive write pulses. rd=0 op -> no pulse.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: load size codes, link register, FSM states.
package wb_pkg;
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;
  localparam logic [4:0] REG_RA  = 5'd31;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;
endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: selects byte/half/word from the raw memory word and extends to W bits.
module load_align
  import wb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rdata_i,
  input  logic [1:0]   size_i,
  input  logic [1:0]   offset_i,
  input  logic         unsigned_i,
  output logic [W-1:0] data_o,
  output logic         misaligned_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{offset_i, 3'b000} +: 8];
  assign half_v = rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o       = rdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      LD_BYTE: data_o = {{(W-8){~unsigned_i & byte_v[7]}}, byte_v};
      LD_HALF: begin
        data_o       = {{(W-16){~unsigned_i & half_v[15]}}, half_v};
        misaligned_o = offset_i[0];
      end
      default: misaligned_o = |offset_i;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM instructions into one registered regfile write each,
// holding loads in WAIT_LOAD until data returns.
module wb_stage
  import wb_pkg::*;
#(
  parameter int          W           = 32,
  parameter int unsigned LINK_OFFSET = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_regwrite,
  input  logic         in_memread,
  input  logic         in_jal,
  input  logic [4:0]   in_rd,
  input  logic [W-1:0] in_alu_result,
  input  logic [W-1:0] in_pc,
  input  logic [1:0]   in_ld_size,
  input  logic         in_ld_unsigned,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  output logic         wb_regwrite,
  output logic         wb_jal_ra,
  output logic [4:0]   wb_wr,
  output logic [W-1:0] wb_data,
  output logic         wb_memread,
  output logic         load_pending,
  output logic [4:0]   pending_rd,
  output logic         err_misalign
);
  wb_state_e   state_q, state_d;
  logic        ready_q, ready_d;
  logic        ld_rw_q, ld_rw_d, ld_uns_q, ld_uns_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [1:0]  ld_size_q, ld_size_d, ld_off_q, ld_off_d;
  logic        regwrite_q, regwrite_d, jal_ra_q, jal_ra_d, memread_q, memread_d;
  logic [4:0]  wr_q, wr_d;
  logic [W-1:0] data_q, data_d;
  logic        err_q, err_d;
  logic [W-1:0] align_data;
  logic        align_mis;
  logic        accept;

  load_align #(.W(W)) u_align (
    .rdata_i     (mem_rdata),
    .size_i      (ld_size_q),
    .offset_i    (ld_off_q),
    .unsigned_i  (ld_uns_q),
    .data_o      (align_data),
    .misaligned_o(align_mis)
  );

  // ready_q is only ever set while the next state is IDLE, so it doubles as the IDLE qualifier.
  assign accept = in_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    ld_rw_d    = ld_rw_q;
    ld_uns_d   = ld_uns_q;
    ld_rd_d    = ld_rd_q;
    ld_size_d  = ld_size_q;
    ld_off_d   = ld_off_q;
    regwrite_d = 1'b0;
    jal_ra_d   = 1'b0;
    memread_d  = 1'b0;
    wr_d       = wr_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_jal) begin
            regwrite_d = in_regwrite;
            jal_ra_d   = in_regwrite;
            wr_d       = REG_RA;
            data_d     = in_pc + W'(LINK_OFFSET);
          end else if (in_memread) begin
            ld_rw_d   = in_regwrite;
            ld_uns_d  = in_ld_unsigned;
            ld_rd_d   = in_rd;
            ld_size_d = in_ld_size;
            ld_off_d  = in_alu_result[1:0];
            state_d   = WAIT_LOAD;
          end else begin
            regwrite_d = in_regwrite & (in_rd != 5'd0);
            wr_d       = in_rd;
            data_d     = in_alu_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_d    = IDLE;
          memread_d  = 1'b1;
          wr_d       = ld_rd_q;
          data_d     = align_data;
          regwrite_d = ld_rw_q & (ld_rd_q != 5'd0) & ~align_mis;
          if (align_mis) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      ld_rw_q    <= 1'b0;
      ld_uns_q   <= 1'b0;
      ld_rd_q    <= '0;
      ld_size_q  <= '0;
      ld_off_q   <= '0;
      regwrite_q <= 1'b0;
      jal_ra_q   <= 1'b0;
      memread_q  <= 1'b0;
      wr_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      ld_rw_q    <= ld_rw_d;
      ld_uns_q   <= ld_uns_d;
      ld_rd_q    <= ld_rd_d;
      ld_size_q  <= ld_size_d;
      ld_off_q   <= ld_off_d;
      regwrite_q <= regwrite_d;
      jal_ra_q   <= jal_ra_d;
      memread_q  <= memread_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign in_ready     = ready_q;
  assign wb_regwrite  = regwrite_q;
  assign wb_jal_ra    = jal_ra_q;
  assign wb_memread   = memread_q;
  assign wb_wr        = wr_q;
  assign wb_data      = data_q;
  assign err_misalign = err_q;
  assign load_pending = (state_q == WAIT_LOAD);
  assign pending_rd   = load_pending ? ld_rd_q : 5'd0;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed cases plus randomized instruction mix against a reference model.
module tb_wb_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_regwrite = 1'b0, in_memread = 1'b0, in_jal = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_alu_result = '0, in_pc = '0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_unsigned = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        in_ready, wb_regwrite, wb_jal_ra, wb_memread, load_pending, err_misalign;
  logic [4:0]  wb_wr, pending_rd;
  logic [31:0] wb_data;

  wb_stage #(.W(32), .LINK_OFFSET(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_jal(in_jal), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_regwrite(wb_regwrite), .wb_jal_ra(wb_jal_ra), .wb_wr(wb_wr), .wb_data(wb_data),
    .wb_memread(wb_memread), .load_pending(load_pending), .pending_rd(pending_rd),
    .err_misalign(err_misalign)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rw, jal, mr, mis;
    logic [4:0]  wr;
    logic [31:0] data;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    fails = 0;
  logic  exp_err = 1'b0;

  // pending load as seen by the model
  logic        ld_rw, ld_uns;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_size, ld_off;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] align_ref(input logic [31:0] rdata, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns,
                                            output logic mis);
    int unsigned v;
    if (size == 2'd0) begin
      v   = (rdata >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      mis = 1'b0;
    end else if (size == 2'd1) begin
      v   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      mis = (off % 2) != 0;
    end else begin
      v   = rdata;
      mis = (off != 0);
    end
    return v;
  endfunction

  // Monitor: every write pulse must match the oldest expected retirement.
  always @(negedge clock) begin
    if (reset) begin
      exp_err = 1'b0;
    end else begin
      if (wb_regwrite || wb_jal_ra || wb_memread) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: wr=%0d data=0x%08h rw=%0b at %0t", wb_wr, wb_data, wb_regwrite, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.mis) exp_err = 1'b1;
          chk("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
          chk("wb_jal_ra", 32'(wb_jal_ra), 32'(e.jal));
          chk("wb_memread", 32'(wb_memread), 32'(e.mr));
          chk("wb_wr", 32'(wb_wr), 32'(e.wr));
          chk("wb_data", wb_data, e.data);
        end
      end
      chk("err_misalign", 32'(err_misalign), 32'(exp_err));
    end
  end

  task automatic issue(input logic rw, input logic mr, input logic jal, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [1:0] size,
                       input logic uns);
    int n = 0;
    exp_t e;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      fails++;
      $display("FAIL in_ready_timeout: in_ready=%0b expected 1", in_ready);
    end
    in_valid = 1'b1; in_regwrite = rw; in_memread = mr; in_jal = jal; in_rd = rd;
    in_alu_result = alu; in_pc = pc; in_ld_size = size; in_ld_unsigned = uns;
    if (jal) begin
      if (rw) begin
        e = '{rw: 1'b1, jal: 1'b1, mr: 1'b0, mis: 1'b0, wr: 5'd31, data: pc + 32'd8};
        sb.push_back(e);
      end
    end else if (mr) begin
      ld_rw = rw; ld_uns = uns; ld_rd = rd; ld_size = size; ld_off = alu[1:0];
    end else if (rw && rd != 0) begin
      e = '{rw: 1'b1, jal: 1'b0, mr: 1'b0, mis: 1'b0, wr: rd, data: alu};
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_return(input int delay, input logic [31:0] rdata);
    exp_t e;
    logic mis;
    logic [31:0] v;
    chk("load_pending_wait", 32'(load_pending), 32'd1);
    chk("pending_rd_wait", 32'(pending_rd), 32'(ld_rd));
    for (int i = 0; i < delay; i++) begin
      chk("in_ready_wait", 32'(in_ready), 32'd0);
      tick();
    end
    v = align_ref(rdata, ld_size, ld_off, ld_uns, mis);
    e = '{rw: ld_rw && ld_rd != 0 && !mis, jal: 1'b0, mr: 1'b1, mis: mis, wr: ld_rd, data: v};
    sb.push_back(e);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk("load_pending_drop", 32'(load_pending), 32'd0);
    chk("pending_rd_drop", 32'(pending_rd), 32'd0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_wr", 32'(wb_wr), 32'd0);
    chk("rst_load_pending", 32'(load_pending), 32'd0);
    chk("rst_err", 32'(err_misalign), 32'd0);
    reset = 1'b0;
    chk("rst_ready_still0", 32'(in_ready), 32'd0);
    tick();
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // ALU op, then jal twice (second with rd=0 and memread=1)
    issue(1, 0, 0, 5'd5, 32'h1234, 32'h400, 2'd0, 0);
    chk("alu_wr_direct", 32'(wb_wr), 32'd5);
    tick();
    chk("alu_pulse_end", 32'(wb_regwrite), 32'd0);
    chk("alu_data_hold", wb_data, 32'h1234);
    issue(1, 0, 1, 5'd7, 32'h0, 32'h0040_0010, 2'd0, 0);
    chk("jal_data_direct", wb_data, 32'h0040_0018);
    issue(1, 1, 1, 5'd0, 32'h3, 32'h0040_0010, 2'd0, 0);
    chk("jal_ld_no_wait", 32'(in_ready), 32'd1);
    chk("jal_ld_no_pending", 32'(load_pending), 32'd0);

    // lb / lbu off=3, lh off=2, misaligned lw
    issue(1, 1, 0, 5'd9, 32'h1003, 32'h0, 2'd0, 0);
    load_return(3, 32'h80FF_7F01);
    chk("lb_data_direct", wb_data, 32'hFFFF_FF80);
    issue(1, 1, 0, 5'd9, 32'h1003, 32'h0, 2'd0, 1);
    load_return(3, 32'h80FF_7F01);
    chk("lbu_data_direct", wb_data, 32'h0000_0080);
    issue(1, 1, 0, 5'd10, 32'h2002, 32'h0, 2'd1, 0);
    load_return(1, 32'hBEEF_0000);
    chk("lh_data_direct", wb_data, 32'hFFFF_BEEF);
    issue(1, 1, 0, 5'd11, 32'h2002, 32'h0, 2'd2, 0);
    load_return(2, 32'h1111_2222);
    chk("lw_mis_nowrite", 32'(wb_regwrite), 32'd0);
    chk("lw_mis_err", 32'(err_misalign), 32'd1);

    // back-to-back ALU ops then rd=0
    for (int i = 1; i <= 4; i++) begin
      issue(1, 0, 0, 5'(i + 12), 32'(i * 32'h111), 32'h0, 2'd0, 0);
      chk("b2b_pulse", 32'(wb_regwrite), 32'd1);
      chk("b2b_wr", 32'(wb_wr), 32'(i + 12));
    end
    issue(1, 0, 0, 5'd0, 32'hDEAD, 32'h0, 2'd0, 0);
    chk("rd0_no_pulse", 32'(wb_regwrite), 32'd0);
    chk("err_sticky", 32'(err_misalign), 32'd1);

    // reset while waiting on a load
    issue(1, 1, 0, 5'd12, 32'h0, 32'h0, 2'd2, 0);
    chk("wait_pending", 32'(load_pending), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_load_pending", 32'(load_pending), 32'd0);
    chk("rstw_pending_rd", 32'(pending_rd), 32'd0);
    chk("rstw_err", 32'(err_misalign), 32'd0);
    chk("rstw_wb_data", wb_data, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("rstw_no_write", 32'(wb_memread), 32'd0);
    chk("rstw_still_idle", 32'(load_pending), 32'd0);

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      int unsigned kind = $urandom_range(0, 99);
      logic [4:0]  rd = 5'($urandom_range(0, 31));
      logic        rw = ($urandom_range(0, 9) != 0);
      logic [31:0] a = $urandom();
      if (kind < 20) begin
        issue(rw, 1'($urandom_range(0, 1)), 1, rd, a, $urandom(), 2'($urandom_range(0, 3)), 0);
      end else if (kind < 55) begin
        issue(rw, 1, 0, rd, a, $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        load_return($urandom_range(0, 3), $urandom());
      end else begin
        mem_rvalid = ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom();
        issue(rw, 0, 0, rd, a, $urandom(), 2'd0, 0);
        mem_rvalid = 1'b0;
      end
    end
    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
